alu_cmd_issuer: RTL

Command-side master for the team's clocked parameterized ALU.
- Accepts ALU operations (func, A, B) on a valid/ready command port and buffers them in a small FIFO.
- Drives the ALU's function and operand inputs one operation at a time and waits the ALU's fixed latency.
- Captures the ALU result and flag bits, then returns them on a valid/ready response port.
- Screens out illegal function codes and divide-by-zero before they reach the ALU.

---
 rtl/alu_cmd_issuer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_issuer.sv
// Command-side master for the clocked ALU: buffers (func, A, B) commands, issues them one at a time,
// screens illegal funcs and divide-by-zero, returns result/flags in order. Optional counters: ALU_ISSUER_STATS_EN.
module alu_cmd_issuer #(
   parameter int N     = 16,
   parameter int DEPTH = 4,
   parameter int LAT   = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [3:0]   cmd_func,
   input  logic [N-1:0] cmd_a,
   input  logic [N-1:0] cmd_b,
   output logic [3:0]   alu_func,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   input  logic [N-1:0] alu_out,
   input  logic [4:0]   alu_flags,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] rsp_data,
   output logic [4:0]   rsp_flags,
   output logic         rsp_err,
   output logic         busy
`ifdef ALU_ISSUER_STATS_EN
   ,
   output logic [15:0]  stat_issued,
   output logic [15:0]  stat_errors
`endif
);

   // Handshake rule for both ports: a transfer happens on the rising edge where valid and ready are both high;
   // the producer holds its payload stable while valid is high and ready is low.

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = $clog2(LAT + 1);
   localparam int EW = 4 + 2 * N;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_n;

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic          fifo_empty, fifo_full;
   logic          push, pop;
   logic          ready_en;
   logic [EW-1:0] head;
   logic [3:0]    head_func;
   logic [N-1:0]  head_a, head_b;
   logic          head_bad;

   logic [CW-1:0] cnt, cnt_n;
   logic [3:0]    alu_func_n;
   logic [N-1:0]  alu_a_n, alu_b_n;
   logic [N-1:0]  rsp_data_n;
   logic [4:0]    rsp_flags_n;
   logic          rsp_err_n;

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // ready_en keeps cmd_ready low through the first cycle after reset release.
   assign cmd_ready = ready_en & ~fifo_full;
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state == IDLE) & ~fifo_empty;

   assign head                      = mem[rd_ptr[AW-1:0]];
   assign {head_func, head_a, head_b} = head;
   assign head_bad = (head_func[3:1] == 3'b111) || ((head_func == 4'b0011) && (head_b == '0));

   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE) | ~fifo_empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {cmd_func, cmd_a, cmd_b};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      alu_func_n  = alu_func;
      alu_a_n     = alu_a;
      alu_b_n     = alu_b;
      rsp_data_n  = rsp_data;
      rsp_flags_n = rsp_flags;
      rsp_err_n   = rsp_err;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               if (head_bad) begin
                  // Rejected commands never touch the ALU drive registers.
                  rsp_data_n  = '0;
                  rsp_flags_n = '0;
                  rsp_err_n   = 1'b1;
                  state_n     = RESP;
               end else begin
                  alu_func_n = head_func;
                  alu_a_n    = head_a;
                  alu_b_n    = head_b;
                  cnt_n      = CW'(LAT);
                  state_n    = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               rsp_data_n  = alu_out;
               rsp_flags_n = alu_flags;
               rsp_err_n   = 1'b0;
               state_n     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         alu_func  <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         alu_func  <= alu_func_n;
         alu_a     <= alu_a_n;
         alu_b     <= alu_b_n;
         rsp_data  <= rsp_data_n;
         rsp_flags <= rsp_flags_n;
         rsp_err   <= rsp_err_n;
      end
   end

`ifdef ALU_ISSUER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issued <= '0;
         stat_errors <= '0;
      end else if (pop) begin
         if (head_bad) begin
            if (stat_errors != 16'hFFFF) stat_errors <= stat_errors + 16'd1;
         end else begin
            if (stat_issued != 16'hFFFF) stat_issued <= stat_issued + 16'd1;
         end
      end
   end
`endif

endmodule
